// File: rtl/regfile_multiport_if.sv
// Decode/writeback-facing bundle of the multiport register file: two read ports,
// one write port and the status flags.
interface regfile_multiport_if #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned NREGS = 32
) ();
    localparam int unsigned AW = $clog2(NREGS);

    logic [AW-1:0]   rs1_addr;
    logic [XLEN-1:0] rs1_data;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs2_data;
    logic            rd_we;
    logic [AW-1:0]   rd_addr;
    logic [XLEN-1:0] rd_data;
    logic            ready;
    logic            wr_dropped;

    modport master (
        output rs1_addr, rs2_addr, rd_we, rd_addr, rd_data,
        input  rs1_data, rs2_data, ready, wr_dropped
    );

    modport slave (
        input  rs1_addr, rs2_addr, rd_we, rd_addr, rd_data,
        output rs1_data, rs2_data, ready, wr_dropped
    );
endinterface

// File: rtl/regfile_multiport.sv
// Integer register file: two combinational read ports with write bypass, one write port,
// optional hardwired x0, and a one-register-per-cycle clear sweep after reset.
module regfile_multiport #(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned NREGS    = 32,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    regfile_multiport_if.slave   bus
);
    localparam int unsigned AW = $clog2(NREGS);

    typedef enum logic [0:0] {StClear, StRun} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   sweep_idx_q, sweep_idx_d;
    logic            wr_dropped_q, wr_dropped_d;
    logic [XLEN-1:0] regs_q [NREGS];

    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            ready;

    assign ready = (state_q == StRun);

    always_comb begin
        state_d      = state_q;
        sweep_idx_d  = sweep_idx_q;
        wr_dropped_d = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = bus.rd_addr;
        mem_wdata    = bus.rd_data;
        unique case (state_q)
            StClear: begin
                mem_we       = 1'b1;
                mem_addr     = sweep_idx_q;
                mem_wdata    = '0;
                wr_dropped_d = bus.rd_we;
                if (sweep_idx_q == AW'(NREGS - 1)) begin
                    state_d = StRun;
                end else begin
                    sweep_idx_d = sweep_idx_q + AW'(1);
                end
            end
            StRun: begin
                mem_we = bus.rd_we && !(ZERO_REG && bus.rd_addr == '0);
            end
            default: state_d = StClear;
        endcase
    end

    // Reset wins over any pending write: storage is left untouched on a reset edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StClear;
            sweep_idx_q  <= '0;
            wr_dropped_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sweep_idx_q  <= sweep_idx_d;
            wr_dropped_q <= wr_dropped_d;
            if (mem_we) begin
                regs_q[mem_addr] <= mem_wdata;
            end
        end
    end

    function automatic logic [XLEN-1:0] read_mux(
        input logic [AW-1:0]   raddr,
        input logic            rdy,
        input logic            we,
        input logic [AW-1:0]   waddr,
        input logic [XLEN-1:0] wdata,
        input logic [XLEN-1:0] stored
    );
        if (!rdy) return '0;
        if (ZERO_REG && raddr == '0) return '0;
        if (we && waddr == raddr) return wdata;
        return stored;
    endfunction

    assign bus.rs1_data   = read_mux(bus.rs1_addr, ready, bus.rd_we, bus.rd_addr, bus.rd_data,
                                     regs_q[bus.rs1_addr]);
    assign bus.rs2_data   = read_mux(bus.rs2_addr, ready, bus.rd_we, bus.rd_addr, bus.rd_data,
                                     regs_q[bus.rs2_addr]);
    assign bus.ready      = ready;
    assign bus.wr_dropped = wr_dropped_q;
endmodule

// File: tb/tb_regfile_multiport.sv
// Directed and randomized checks of regfile_multiport in three configurations:
// 64x32 with x0, 64x32 without x0, and 32x8 with x0 against an array model.
module tb_regfile_multiport;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_multiport_if #(.XLEN(64), .NREGS(32)) ifa ();
    regfile_multiport_if #(.XLEN(64), .NREGS(32)) ifb ();
    regfile_multiport_if #(.XLEN(32), .NREGS(8))  ifc ();

    regfile_multiport #(.XLEN(64), .NREGS(32), .ZERO_REG(1'b1)) dut_a (
        .clk_i(clk), .reset_i(reset), .bus(ifa.slave));
    regfile_multiport #(.XLEN(64), .NREGS(32), .ZERO_REG(1'b0)) dut_b (
        .clk_i(clk), .reset_i(reset), .bus(ifb.slave));
    regfile_multiport #(.XLEN(32), .NREGS(8), .ZERO_REG(1'b1)) dut_c (
        .clk_i(clk), .reset_i(reset), .bus(ifc.slave));

    int total = 0;
    int bad   = 0;

    // Reference state for the small instance: plain array of architectural values.
    logic [31:0] cm [8];
    logic        cwe;
    logic [2:0]  cwa, cr1, cr2;
    logic [31:0] cwd;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] c_ref(input logic [2:0] a);
        if (a == 3'd0) return 32'd0;
        if (cwe && cwa == a) return cwd;
        return cm[a];
    endfunction

    initial begin
        int n;
        int c_at;
        reset = 1'b1;
        ifa.rs1_addr = 5'd5; ifa.rs2_addr = 5'd6; ifa.rd_we = 1'b0;
        ifa.rd_addr = '0; ifa.rd_data = '0;
        ifb.rs1_addr = '0; ifb.rs2_addr = '0; ifb.rd_we = 1'b0;
        ifb.rd_addr = '0; ifb.rd_data = '0;
        ifc.rs1_addr = '0; ifc.rs2_addr = '0; ifc.rd_we = 1'b0;
        ifc.rd_addr = '0; ifc.rd_data = '0;
        repeat (3) tick();
        chk("rst_ready", ifa.ready, 0);
        chk("rst_dropped", ifa.wr_dropped, 0);
        chk("rst_rs1", ifa.rs1_data, 0);
        chk("rst_rs2", ifa.rs2_data, 0);

        // Release; a write two cycles in must be dropped and flagged for one cycle.
        reset = 1'b0;
        n = 0; c_at = 0;
        tick(); n++;
        tick(); n++;
        ifa.rd_we = 1'b1; ifa.rd_addr = 5'd7; ifa.rd_data = 64'h1234;
        tick(); n++;
        chk("drop_pulse", ifa.wr_dropped, 1);
        ifa.rd_we = 1'b0;
        tick(); n++;
        chk("drop_clear", ifa.wr_dropped, 0);
        while (!ifa.ready && n < 100) begin
            tick(); n++;
            if (ifc.ready && c_at == 0) c_at = n;
        end
        chk("ready_latency_32", n, 32);
        chk("ready_latency_8", c_at, 8);

        for (int r = 0; r < 32; r++) begin
            ifa.rs1_addr = 5'(r); ifa.rs2_addr = 5'(31 - r);
            #1;
            chk("swept_rs1", ifa.rs1_data, 0);
            chk("swept_rs2", ifa.rs2_data, 0);
        end

        ifa.rd_we = 1'b1; ifa.rd_addr = 5'd5; ifa.rd_data = 64'hDEADBEEF_CAFEF00D;
        ifa.rs1_addr = 5'd5; ifa.rs2_addr = 5'd5;
        #1;
        chk("bypass_rs1", ifa.rs1_data, 64'hDEADBEEF_CAFEF00D);
        chk("bypass_rs2", ifa.rs2_data, 64'hDEADBEEF_CAFEF00D);
        tick();
        ifa.rd_we = 1'b0;
        #1;
        chk("stored_rs1", ifa.rs1_data, 64'hDEADBEEF_CAFEF00D);
        chk("stored_rs2", ifa.rs2_data, 64'hDEADBEEF_CAFEF00D);

        ifa.rd_we = 1'b1; ifa.rd_addr = 5'd0; ifa.rd_data = '1;
        ifa.rs1_addr = 5'd0; ifa.rs2_addr = 5'd0;
        ifb.rd_we = 1'b1; ifb.rd_addr = 5'd0; ifb.rd_data = '1;
        ifb.rs1_addr = 5'd0; ifb.rs2_addr = 5'd0;
        #1;
        chk("x0_during_a", ifa.rs1_data, 0);
        chk("x0_during_b", ifb.rs2_data, 64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        chk("x0_no_drop", ifa.wr_dropped, 0);
        ifa.rd_we = 1'b0; ifb.rd_we = 1'b0;
        #1;
        chk("x0_after_a", ifa.rs2_data, 0);
        chk("x0_after_b", ifb.rs1_data, 64'hFFFF_FFFF_FFFF_FFFF);
        ifa.rs1_addr = 5'd7;
        #1;
        chk("x7_dropped_zero", ifa.rs1_data, 0);

        for (int r = 0; r < 32; r++) begin
            ifa.rd_we = 1'b1; ifa.rd_addr = 5'(r); ifa.rd_data = 64'(r);
            tick();
        end
        ifa.rd_we = 1'b0; ifa.rs1_addr = 5'd9; ifa.rs2_addr = 5'd31;
        #1;
        chk("fill_x9", ifa.rs1_data, 9);
        chk("fill_x31", ifa.rs2_data, 31);

        // Reset in RUN, then again at sweep index 10 together with a write.
        reset = 1'b1;
        tick();
        chk("run_reset_ready", ifa.ready, 0);
        reset = 1'b0;
        repeat (10) tick();
        reset = 1'b1;
        ifa.rd_we = 1'b1; ifa.rd_addr = 5'd3; ifa.rd_data = 64'h55;
        tick();
        chk("midsweep_ready", ifa.ready, 0);
        chk("reset_beats_write", ifa.wr_dropped, 0);
        reset = 1'b0; ifa.rd_we = 1'b0;
        n = 0;
        while (!ifa.ready && n < 100) begin
            tick(); n++;
        end
        chk("resweep_latency", n, 32);
        for (int r = 0; r < 32; r++) begin
            ifa.rs1_addr = 5'(r); ifa.rs2_addr = 5'(r);
            #1;
            chk("resweep_rs1", ifa.rs1_data, 0);
            chk("resweep_rs2", ifa.rs2_data, 0);
        end

        // Random traffic on the 8-entry instance.
        chk("c_ready", ifc.ready, 1);
        for (int i = 0; i < 8; i++) cm[i] = 32'd0;
        for (int i = 0; i < 1000; i++) begin
            cwe = 1'($urandom_range(0, 1));
            cwa = 3'($urandom_range(0, 7));
            cwd = $urandom;
            cr1 = ($urandom_range(0, 3) == 0) ? cwa : 3'($urandom_range(0, 7));
            cr2 = ($urandom_range(0, 3) == 0) ? cwa : 3'($urandom_range(0, 7));
            ifc.rd_we = cwe; ifc.rd_addr = cwa; ifc.rd_data = cwd;
            ifc.rs1_addr = cr1; ifc.rs2_addr = cr2;
            #1;
            chk("rand_rs1", ifc.rs1_data, c_ref(cr1));
            chk("rand_rs2", ifc.rs2_data, c_ref(cr2));
            tick();
            if (cwe && cwa != 3'd0) cm[cwa] = cwd;
        end
        ifc.rd_we = 1'b0;
        chk("rand_no_drop", ifc.wr_dropped, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
